// File: rtl/result_packer.sv
// result_packer
//   Packs 16-bit engine results, two per 32-bit word, into the result FIFO.
//   The first result of each pair goes to the low half and the second to the
//   high half. A trailing odd result is padded with PAD_VALUE in the high half
//   and flushed. A one-cycle done pulse marks the end of every job.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   start, total        one-cycle job start, number of results in the job
//   in_valid, in_data   engine result stream
//   in_ready            packer takes in_data when in_valid && in_ready
//   fifo_full           result FIFO full flag
//   fifo_wr_en, fifo_din  FIFO write strobe and packed word
//   busy                job in progress (RUN or FLUSH)
//   done                one-cycle completion pulse
//   word_count          words written in the current/last job
module result_packer #(
  parameter int                DATA_W    = 16,
  parameter int                WORD_W    = 32,
  parameter int                CNT_W     = 24,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  total,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [WORD_W-1:0] fifo_din,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   remaining;
  logic [DATA_W-1:0]  half_data;
  logic               half_valid;
  logic               out_valid;
  logic               accept;
  logic               out_free;

  // The out-register is free either when it is empty or when its word is
  // leaving this cycle; this is what gives one result per cycle throughput.
  always_comb begin
    fifo_wr_en = out_valid && !fifo_full;
    out_free   = !out_valid || fifo_wr_en;
    in_ready   = (state == RUN) && (remaining != '0) && (!half_valid || out_free);
    accept     = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      remaining  <= '0;
      half_data  <= '0;
      half_valid <= 1'b0;
      out_valid  <= 1'b0;
      fifo_din   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      done <= 1'b0;

      // Drain; a load in the same cycle below overrides the clear.
      if (fifo_wr_en) begin
        out_valid  <= 1'b0;
        word_count <= word_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            remaining  <= total;
            word_count <= '0;
            half_valid <= 1'b0;
            if (total == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end

        RUN: begin
          if (accept) begin
            remaining <= remaining - 1'b1;
            if (!half_valid) begin
              half_data  <= in_data;
              half_valid <= 1'b1;
            end else begin
              fifo_din   <= {in_data, half_data};
              out_valid  <= 1'b1;
              half_valid <= 1'b0;
            end
          end else if (remaining == '0) begin
            if (half_valid) begin
              state <= FLUSH;
            end else if (out_free) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        FLUSH: begin
          if (half_valid) begin
            if (out_free) begin
              fifo_din   <= {PAD_VALUE, half_data};
              out_valid  <= 1'b1;
              half_valid <= 1'b0;
            end
          end else if (out_free) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_packer.sv
module tb_result_packer;
  localparam int DATA_W = 16;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 24;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  total = '0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr_en;
  logic [WORD_W-1:0] fifo_din;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  word_count;

  result_packer #(
    .DATA_W(DATA_W), .WORD_W(WORD_W), .CNT_W(CNT_W), .PAD_VALUE(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total(total),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: accepted results become words in a queue of expectations
  logic [31:0] exp_q[$];
  logic [15:0] src[$];
  int          m_tot = 0;
  int          m_acc = 0;
  bit          m_half_v = 0;
  logic [15:0] m_half = '0;
  bit          m_active = 0;
  int          done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (fifo_wr_en) begin
        chk("wr_while_full", {31'b0, fifo_full}, 32'd0);
        if (exp_q.size() > 0) chk("word", fifo_din, exp_q.pop_front());
        else chk("spurious_wr", {31'b0, fifo_wr_en}, 32'd0);
      end
      if (m_active && in_valid && in_ready) begin
        if (m_acc >= m_tot) begin
          chk("in_ready_limit", {31'b0, in_ready}, 32'd0);
        end else begin
          if (m_half_v) begin
            exp_q.push_back({in_data, m_half});
            m_half_v = 0;
          end else begin
            m_half   = in_data;
            m_half_v = 1;
          end
          m_acc++;
          if (m_acc == m_tot && m_half_v) begin
            exp_q.push_back({16'h0000, m_half});
            m_half_v = 0;
          end
        end
      end
      if (m_active && done) begin
        done_cnt++;
        chk("word_count", {8'b0, word_count}, (m_tot + 1) / 2);
        chk("words_left", exp_q.size(), 32'd0);
        chk("acc_total", m_acc, m_tot);
      end
    end
  end

  task automatic run_job(input int tot, input int vprob, input int fprob,
                         input int hold_at, input int rst_at, input bit restart);
    int  iter;
    bit  held;
    iter = 0;
    held = 0;
    @(posedge clk); #1;
    m_tot = tot; m_acc = 0; m_half_v = 0; exp_q.delete();
    done_cnt = 0; m_active = 1;
    total = tot[CNT_W-1:0];
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start", {31'b0, busy}, {31'b0, (tot != 0)});
    if (tot == 0) chk("zero_done", {31'b0, done}, 32'd1);

    while (iter < 2000) begin
      if (iter > 0) begin
        @(posedge clk); #1;
      end
      iter++;
      if (done_cnt > 0) break;
      if (rst_at >= 0 && m_acc == rst_at) begin
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
        chk("rst_din", fifo_din, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_word_count", {8'b0, word_count}, 32'd0);
        m_active = 0;
        exp_q.delete();
        src.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      start = (restart && iter == 3);
      if (start) total = 24'd9;
      if (hold_at >= 0 && !held && m_acc >= hold_at) begin
        held = 1;
        for (int c = 0; c < 10; c++) begin
          if (c > 0) begin
            @(posedge clk); #1;
          end
          start = 1'b0;
          fifo_full = 1'b1;
          in_valid = 1'b1;
          in_data = (m_acc < src.size()) ? src[m_acc] : 16'($urandom);
        end
        #1;
        chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
        if (exp_q.size() > 0) chk("hold_din", fifo_din, exp_q[0]);
        fifo_full = 1'b0;
        continue;
      end
      fifo_full = ($urandom_range(0, 99) < fprob);
      in_valid  = ($urandom_range(0, 99) < vprob);
      in_data   = (m_acc < src.size()) ? src[m_acc] : 16'($urandom);
    end
    if (done_cnt == 0) chk("timeout", done_cnt, 32'd1);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      fifo_full = 1'b0;
      #1;
      chk("idle_ready", {31'b0, in_ready}, 32'd0);
    end
    chk("done_once", done_cnt, 32'd1);
    chk("busy_end", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    m_active = 0;
    src.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    chk("reset_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("reset_din", fifo_din, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_word_count", {8'b0, word_count}, 32'd0);
    rst_n = 1'b1;

    src = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_job(4, 100, 0, -1, -1, 0);
    src = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_job(3, 100, 0, -1, -1, 0);
    run_job(6, 100, 0, 2, -1, 0);
    run_job(0, 100, 0, -1, -1, 0);
    run_job(8, 100, 0, -1, 3, 0);
    run_job(2, 100, 0, -1, -1, 0);
    run_job(5, 100, 0, -1, -1, 1);
    run_job(7, 60, 30, -1, -1, 1);

    for (int j = 0; j < 30; j++) begin
      run_job($urandom_range(0, 17), $urandom_range(30, 100),
              $urandom_range(0, 60), -1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
